// File: rtl/arb_mux.sv
// Round-robin / forced-select N:1 arbiter feeding a single registered output slot.
// The output slot is a two-state skid-free register that sustains one word per cycle.
module arb_mux #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 8,
    localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      force_en,
    input  logic [SELW-1:0]           force_sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state, state_next;
    logic [SELW-1:0]  rr_ptr;
    logic             load_ok;
    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;
    logic             transfer;
    logic [WIDTH-1:0] sel_data;

    // Grant search: forced index, or first requester at/above rr_ptr, then wrap to 0.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (force_en) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (force_sel == SELW'(i) && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!grant_vld && i >= int'(rr_ptr) && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (!grant_vld && i < int'(rr_ptr) && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
        end
    end

    assign load_ok  = (state == EMPTY) || out_ready;
    assign transfer = load_ok && grant_vld && !reset;

    always_comb begin
        in_ready = '0;
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_idx == SELW'(i)) begin
                in_ready[i] = transfer;
                sel_data    = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_next = state;
        if (transfer) begin
            state_next = FULL;
        end else if (state == FULL && out_ready) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Output register and round-robin pointer; forced transfers leave the pointer alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
            out_chan <= '0;
            rr_ptr   <= '0;
        end else if (transfer) begin
            out_data <= sel_data;
            out_chan <= grant_idx;
            if (!force_en) begin
                rr_ptr <= (grant_idx == SELW'(CHANNELS - 1)) ? '0 : grant_idx + SELW'(1);
            end
        end
    end

    assign out_valid = (state == FULL);

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux (8 channels x 16 bits): vector table, directed corner sequences,
// and a randomized run against a queue-free behavioural model of the arbiter.
module tb_arb_mux;

    localparam int W  = 16;
    localparam int CH = 8;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic            force_en;
    logic [SW-1:0]   force_sel;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_chan;
    logic            out_valid;
    logic            out_ready;

    int n_chk  = 0;
    int n_fail = 0;

    arb_mux #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .force_en(force_en), .force_sel(force_sel),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [7:0]   vld;
        logic         fe;
        logic [2:0]   fs;
        logic         ordy;
        logic [7:0]   exp_ready;
        logic         exp_ovld;
        logic [2:0]   exp_chan;
        logic [15:0]  exp_data;
    } vec_t;

    // Behavioural model state
    bit          m_full;
    logic [15:0] m_data;
    int          m_chan;
    int          m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] v, input logic fe,
                         input logic [2:0] fs, input logic ordy);
        reset     = r;
        in_valid  = v;
        force_en  = fe;
        force_sel = fs;
        out_ready = ordy;
    endtask

    task automatic set_fixed_data();
        for (int i = 0; i < CH; i++) in_data[i*W +: W] = 16'h1000 + 16'(i);
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_grant(input logic [7:0] v, input logic fe, input logic [2:0] fs);
        if (fe) return (int'(fs) < CH && v[fs]) ? int'(fs) : -1;
        for (int k = 0; k < CH; k++) begin
            int c;
            c = (m_ptr + k) % CH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // One model-checked cycle with whatever inputs are currently driven
    task automatic model_cycle();
        int g;
        bit ok;
        logic [7:0] er;
        @(negedge clk);
        g  = model_grant(in_valid, force_en, force_sel);
        ok = !reset && (!m_full || out_ready) && g >= 0;
        er = ok ? 8'(1 << g) : 8'h00;
        chk("rand_in_ready", 32'(in_ready), 32'(er));
        if (reset) begin
            m_full = 0; m_data = 16'h0; m_chan = 0; m_ptr = 0;
        end else if (ok) begin
            m_full = 1;
            m_data = in_data[g*W +: W];
            m_chan = g;
            if (!force_en) m_ptr = (g + 1) % CH;
        end else if (out_ready) begin
            m_full = 0;
        end
        tick();
        chk("rand_out_valid", 32'(out_valid), 32'(m_full));
        chk("rand_out_data", 32'(out_data), 32'(m_data));
        chk("rand_out_chan", 32'(out_chan), 32'(m_chan));
    endtask

    vec_t tbl[15];

    initial begin
        drive(1'b1, 8'h00, 1'b0, 3'd0, 1'b1);
        set_fixed_data();

        //            rst  vld    fe  fs  ordy ready  ovld chan  data
        tbl[0]  = '{1'b1, 8'hFF, 0, 3'd0, 1, 8'h00, 0, 3'd0, 16'h0000};
        tbl[1]  = '{1'b0, 8'h24, 0, 3'd0, 1, 8'h04, 1, 3'd2, 16'h1002};
        tbl[2]  = '{1'b0, 8'h24, 0, 3'd0, 0, 8'h00, 1, 3'd2, 16'h1002};
        tbl[3]  = '{1'b0, 8'h24, 0, 3'd0, 1, 8'h20, 1, 3'd5, 16'h1005};
        tbl[4]  = '{1'b0, 8'h84, 0, 3'd0, 1, 8'h80, 1, 3'd7, 16'h1007};
        tbl[5]  = '{1'b0, 8'h84, 0, 3'd0, 1, 8'h04, 1, 3'd2, 16'h1002};
        tbl[6]  = '{1'b0, 8'hFF, 1, 3'd3, 1, 8'h08, 1, 3'd3, 16'h1003};
        tbl[7]  = '{1'b0, 8'hFF, 1, 3'd3, 1, 8'h08, 1, 3'd3, 16'h1003};
        tbl[8]  = '{1'b0, 8'hFF, 0, 3'd0, 1, 8'h08, 1, 3'd3, 16'h1003};
        tbl[9]  = '{1'b0, 8'hEF, 1, 3'd4, 1, 8'h00, 0, 3'd3, 16'h1003};
        tbl[10] = '{1'b0, 8'hEF, 1, 3'd4, 1, 8'h00, 0, 3'd3, 16'h1003};
        tbl[11] = '{1'b0, 8'h00, 0, 3'd0, 1, 8'h00, 0, 3'd3, 16'h1003};
        tbl[12] = '{1'b0, 8'h10, 0, 3'd0, 1, 8'h10, 1, 3'd4, 16'h1004};
        tbl[13] = '{1'b1, 8'hFF, 0, 3'd0, 1, 8'h00, 0, 3'd0, 16'h0000};
        tbl[14] = '{1'b0, 8'h30, 0, 3'd0, 1, 8'h10, 1, 3'd4, 16'h1004};

        tick();
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].fe, tbl[i].fs, tbl[i].ordy);
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_ready));
            tick();
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ovld));
            chk($sformatf("vec%0d_out_chan", i), 32'(out_chan), 32'(tbl[i].exp_chan));
            chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].exp_data));
        end

        // All channels valid: strict rotation 0..7,0 at full rate
        drive(1'b1, 8'hFF, 1'b0, 3'd0, 1'b1);
        tick();
        chk("rr_after_reset_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk($sformatf("rr%0d_chan", k), 32'(out_chan), 32'(k % CH));
            chk($sformatf("rr%0d_data", k), 32'(out_data), 32'(16'h1000 + 16'(k % CH)));
            chk($sformatf("rr%0d_valid", k), 32'(out_valid), 32'd1);
        end

        // Stall for 5 cycles holding channel 0, then resume with channel 1
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'h00);
            tick();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_chan", 32'(out_chan), 32'd0);
            chk("stall_data", 32'(out_data), 32'h1000);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("resume_in_ready", 32'(in_ready), 32'h02);
        tick();
        chk("resume_chan", 32'(out_chan), 32'd1);
        chk("resume_data", 32'(out_data), 32'h1001);

        // Randomized run against the behavioural model, starting from reset
        drive(1'b1, 8'h00, 1'b0, 3'd0, 1'b1);
        tick();
        m_full = 0; m_data = 16'h0; m_chan = 0; m_ptr = 0;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < CH; i++) in_data[i*W +: W] = 16'($urandom);
            reset     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 1) == 0) ? 8'($urandom) : (8'($urandom) & 8'($urandom));
            force_en  = ($urandom_range(0, 3) == 0);
            force_sel = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            model_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
